act_interp_scheduler: RTL and testbench
=======================================

Name: act_interp_scheduler

Overview:
- Shares one activation-function lookup/interpolation datapath among N_REQ neuron requesters of a layer.
- Round-robin arbitrates the requests and splits each input into a table index and a fractional remainder.
- Sequences two reads of an external single-port table ROM (base entry, then next entry) and computes the linearly interpolated activation.
- Returns the activation with the requester ID over a valid/ready response port.

Parameters:
N_REQ, 4, number of requesters
ID_W, 2, requester ID width (clog2(N_REQ))
DATA_W, 8, signed fixed-point data width
FRAC_BITS, 4, fractional bits of input (remaining field width)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  N_REQ  per-requester request valid
req_data  in  N_REQ*DATA_W  per-requester signed input x; requester i uses slice [i*DATA_W +: DATA_W]
req_ready  out  N_REQ  one-hot acceptance strobe
rom_en  out  1  table read enable
rom_addr  out  DATA_W-FRAC_BITS  table address
rom_data  in  DATA_W  signed table entry, valid 1 cycle after rom_en
resp_valid  out  1  result valid
resp_ready  in  1  consumer accepts result
resp_id  out  ID_W  index of the served requester
resp_value  out  DATA_W  signed interpolated activation
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset, asynchronous: state=IDLE, rr_ptr=N_REQ-1, so requester 0 has first priority. All outputs 0.
- FSM states: IDLE -> FETCH_BASE -> FETCH_NEXT -> INTERP -> RESP -> IDLE.
- IDLE, grant selection:
  - Search requesters starting at rr_ptr+1 (mod N_REQ); the first with req_valid=1 is granted.
  - req_ready[grant]=1 combinationally in the same cycle; req_ready is never high outside IDLE.
  - On the clock edge, register: id, rr_ptr=id, idx, rem.
  - idx = signed x[DATA_W-1:FRAC_BITS] + 2^(DATA_W-FRAC_BITS-1), giving 0..15 for the defaults.
  - rem = x[FRAC_BITS-1:0] unsigned.
- FETCH_BASE: rom_en=1, rom_addr=idx.
- FETCH_NEXT:
  - Capture base=rom_data.
  - rom_en=1, rom_addr=next_idx, where next_idx = idx+1, clamped to the maximum index (all ones).
- INTERP:
  - Capture next=rom_data.
  - diff = next-base, DATA_W+1 bits signed.
  - prod = diff*rem, 2*DATA_W bits signed.
  - val = base + (prod >>> FRAC_BITS), arithmetic shift (floor).
  - Register val truncated to DATA_W. The result lies between base and next, so truncation is lossless.
- RESP:
  - resp_valid=1; resp_id and resp_value are stable until resp_valid & resp_ready.
  - On that handshake go to IDLE.
- Timing:
  - Acceptance edge to resp_valid=1 is 4 cycles.
  - Minimum spacing between acceptances is 5 cycles.
  - rom_en is high for exactly 2 cycles per request.
- Boundary conditions:
  - rem=0 -> result equals base exactly.
  - idx at maximum -> next_idx=idx, result=base.
  - Most negative x (0x80) -> idx=0.
  - No requests in IDLE -> remain IDLE, rom_en=0.
  - Requester holds req_valid and req_data stable until it sees req_ready.
  - Only the requester pointed to by rr_ptr+1 can win when all requesters are valid; arbitration is starvation-free.
- Reset mid-operation: immediate return to IDLE; the in-flight request is discarded with no response. The requester already received req_ready and must reissue.
- The block never asserts two req_ready bits simultaneously.

Test Plan:
- ROM[8]=8, ROM[9]=11; req0 x=0x08 -> rom_addr 8 then 9; resp_id=0, resp_value=9, 4 cycles after req_ready[0].
- ROM[10]=20, ROM[11]=4; req2 x=0x2C -> resp_value=8 (negative slope: -192>>>4=-12).
- x=0x7F with ROM[15]=15 -> both reads at address 15, resp_value=15; x=0x80 -> first read at address 0.
- All four req_valid held high after reset -> grants in order 0,1,2,3,0; each req_ready a single-cycle one-hot pulse; resp_id sequence matches.
- resp_ready held low 10 cycles -> resp_valid, resp_id, resp_value stable; no req_ready; busy=1; accept resumes the cycle after the handshake.
- rst asserted during FETCH_NEXT -> outputs 0 and state IDLE immediately, no resp_valid; next request after release is served by requester 0 first.

Source files
------------

// File: rtl/act_interp_scheduler.sv
// Shared activation-function lookup/interpolation engine: round-robin arbitration over
// N_REQ requesters, two table-ROM reads per request, linear interpolation, valid/ready response.
module act_interp_scheduler #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned ID_W      = 2,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned FRAC_BITS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*DATA_W-1:0]       req_data,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          rom_en,
    output logic [DATA_W-FRAC_BITS-1:0]   rom_addr,
    input  logic [DATA_W-1:0]             rom_data,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [ID_W-1:0]               resp_id,
    output logic [DATA_W-1:0]             resp_value,
    output logic                          busy
);

    localparam int unsigned IDX_W  = DATA_W - FRAC_BITS;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam logic [IDX_W-1:0] IDX_OFS = {1'b1, {(IDX_W-1){1'b0}}};
    localparam logic [IDX_W-1:0] IDX_MAX = {IDX_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_BASE,
        S_FETCH_NEXT,
        S_INTERP,
        S_RESP
    } state_e;

    state_e                    state_q, state_d;
    logic [ID_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]           id_q, id_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [FRAC_BITS-1:0]      rem_q, rem_d;
    logic signed [DATA_W-1:0]  base_q, base_d;
    logic [DATA_W-1:0]         val_q, val_d;

    logic                      gnt_found;
    logic [ID_W-1:0]           gnt_id;
    logic [DATA_W-1:0]         sel_x;
    logic [IDX_W-1:0]          next_idx;
    logic signed [DATA_W:0]    diff;
    logic signed [PROD_W-1:0]  prod;
    logic signed [PROD_W-1:0]  base_ext;
    logic signed [PROD_W-1:0]  sum;

    // Round-robin search starting just after the last served requester
    always_comb begin
        int unsigned cand;
        cand      = 0;
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = (32'(rr_ptr_q) + k) % N_REQ;
            if (!gnt_found && req_valid[ID_W'(cand)]) begin
                gnt_found = 1'b1;
                gnt_id    = ID_W'(cand);
            end
        end
    end

    always_comb begin
        sel_x = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == gnt_id) begin
                sel_x = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign next_idx = (idx_q == IDX_MAX) ? idx_q : idx_q + IDX_W'(1);

    // Interpolation uses the second ROM word straight off the bus during S_INTERP
    assign diff     = $signed({rom_data[DATA_W-1], rom_data}) - $signed({base_q[DATA_W-1], base_q});
    assign prod     = PROD_W'(diff) * $signed({{(PROD_W-FRAC_BITS){1'b0}}, rem_q});
    assign base_ext = PROD_W'(base_q);
    assign sum      = base_ext + (prod >>> FRAC_BITS);

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        idx_d     = idx_q;
        rem_d     = rem_q;
        base_d    = base_q;
        val_d     = val_q;
        req_ready = '0;
        rom_en    = 1'b0;
        rom_addr  = '0;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    req_ready = N_REQ'(1) << gnt_id;
                    id_d      = gnt_id;
                    rr_ptr_d  = gnt_id;
                    idx_d     = sel_x[DATA_W-1:FRAC_BITS] + IDX_OFS;
                    rem_d     = sel_x[FRAC_BITS-1:0];
                    state_d   = S_FETCH_BASE;
                end
            end
            S_FETCH_BASE: begin
                rom_en   = 1'b1;
                rom_addr = idx_q;
                state_d  = S_FETCH_NEXT;
            end
            S_FETCH_NEXT: begin
                base_d   = rom_data;
                rom_en   = 1'b1;
                rom_addr = next_idx;
                state_d  = S_INTERP;
            end
            S_INTERP: begin
                val_d   = DATA_W'(sum);
                state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= ID_W'(N_REQ - 1);
            id_q     <= '0;
            idx_q    <= '0;
            rem_q    <= '0;
            base_q   <= '0;
            val_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            idx_q    <= idx_d;
            rem_q    <= rem_d;
            base_q   <= base_d;
            val_q    <= val_d;
        end
    end

    assign resp_valid = (state_q == S_RESP);
    assign resp_id    = id_q;
    assign resp_value = val_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_act_interp_scheduler.sv
// Scoreboard bench for act_interp_scheduler: directed requests push expected ROM addresses
// and responses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_act_interp_scheduler;

    localparam int unsigned N_REQ     = 4;
    localparam int unsigned ID_W      = 2;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned FRAC_BITS = 4;
    localparam int unsigned IDX_W     = DATA_W - FRAC_BITS;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] val;
    } exp_t;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*DATA_W-1:0]     req_data;
    logic [N_REQ-1:0]            req_ready;
    logic                        rom_en;
    logic [IDX_W-1:0]            rom_addr;
    logic [DATA_W-1:0]           rom_data = '0;
    logic                        resp_valid;
    logic                        resp_ready;
    logic [ID_W-1:0]             resp_id;
    logic [DATA_W-1:0]           resp_value;
    logic                        busy;

    logic [DATA_W-1:0] rom [16];
    exp_t              sb_q[$];
    logic [IDX_W-1:0]  addr_q[$];
    exp_t              mon_e;
    logic [IDX_W-1:0]  mon_a;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

    act_interp_scheduler #(
        .N_REQ(N_REQ), .ID_W(ID_W), .DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_value(resp_value), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: ROM address stream, response stream, one-hot acceptance
    always @(negedge clk) begin
        if (!rst) begin
            chk("req_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            if (rom_en) begin
                if (addr_q.size() == 0) begin
                    chk("rom_en_unexpected", 32'(rom_en), 32'd0);
                end else begin
                    mon_a = addr_q.pop_front();
                    chk("rom_addr", 32'(rom_addr), 32'(mon_a));
                end
            end
            if (resp_valid && resp_ready) begin
                if (sb_q.size() == 0) begin
                    chk("resp_unexpected", 32'(resp_valid), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("resp_id", 32'(resp_id), 32'(mon_e.id));
                    chk("resp_value", 32'(resp_value), 32'(mon_e.val));
                end
            end
        end
    end

    task automatic expect_req(input int id, input logic [7:0] x, input logic [3:0] a0,
                              input logic [3:0] a1, input logic [7:0] v);
        exp_t e;
        e.id  = ID_W'(id);
        e.val = v;
        addr_q.push_back(a0);
        addr_q.push_back(a1);
        sb_q.push_back(e);
        req_data[id*DATA_W +: DATA_W] = x;
    endtask

    task automatic wait_grant(input int id, input string name);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready != '0) break;
        end
        chk(name, 32'(req_ready), 32'(1) << id);
    endtask

    task automatic drain();
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && addr_q.size() == 0) break;
        end
        @(posedge clk); #1;
    endtask

    // Single isolated request, also measuring accept-to-response latency
    task automatic single(input int id, input logic [7:0] x, input logic [3:0] a0,
                          input logic [3:0] a1, input logic [7:0] v);
        int lat;
        lat = 99;
        expect_req(id, x, a0, a1, v);
        req_valid[id] = 1'b1;
        wait_grant(id, "single_grant");
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = n;
                break;
            end
        end
        chk("latency", 32'(lat), 32'd4);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int order [5];
        order = '{0, 1, 2, 3, 0};
        rst        = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        resp_ready = 1'b1;
        rom = '{8'hF0, 8'hF4, 8'hF8, 8'hFC, 8'h00, 8'h02, 8'h04, 8'h06,
                8'h08, 8'h0B, 8'h14, 8'h04, 8'h1E, 8'hE2, 8'h0A, 8'h0F};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rom_en", 32'(rom_en), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_resp_value", 32'(resp_value), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        repeat (3) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_rom_en", 32'(rom_en), 32'd0);
        end
        @(posedge clk); #1;

        single(0, 8'h08, 4'd8,  4'd9,  8'h09);
        single(2, 8'h2C, 4'd10, 4'd11, 8'h08);
        single(1, 8'h7F, 4'd15, 4'd15, 8'h0F);
        single(3, 8'h80, 4'd0,  4'd1,  8'hF0);
        single(0, 8'h4A, 4'd12, 4'd13, 8'hF8);

        // Reset while the second ROM read is in flight
        addr_q.push_back(4'd8);
        req_data[1*DATA_W +: DATA_W] = 8'h08;
        req_valid[1] = 1'b1;
        wait_grant(1, "midrst_grant");
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rom_en", 32'(rom_en), 32'd0);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_resp_value", 32'(resp_value), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("postrst_busy", 32'(busy), 32'd0);
            chk("postrst_resp_valid", 32'(resp_valid), 32'd0);
        end
        @(posedge clk); #1;

        // All requesters valid: rotation 0,1,2,3 then 0 again
        expect_req(0, 8'h08, 4'd8,  4'd9,  8'h09);
        expect_req(1, 8'h2C, 4'd10, 4'd11, 8'h08);
        expect_req(2, 8'h7F, 4'd15, 4'd15, 8'h0F);
        expect_req(3, 8'h80, 4'd0,  4'd1,  8'hF0);
        begin
            exp_t e;
            e.id  = 2'd0;
            e.val = 8'hF8;
            addr_q.push_back(4'd12);
            addr_q.push_back(4'd13);
            sb_q.push_back(e);
        end
        req_valid = 4'hF;
        for (int g = 0; g < 5; g++) begin
            wait_grant(order[g], "rr_grant");
            @(posedge clk); #1;
            if (g == 0) req_data[0 +: DATA_W] = 8'h4A;
            else        req_valid[order[g]] = 1'b0;
            @(negedge clk);
            chk("ready_pulse", 32'(req_ready), 32'd0);
        end
        drain();

        // Response backpressure with a competing request pending
        resp_ready = 1'b0;
        expect_req(2, 8'h08, 4'd8, 4'd9, 8'h09);
        req_valid[2] = 1'b1;
        wait_grant(2, "bp_grant");
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        req_data[1*DATA_W +: DATA_W] = 8'h2C;
        req_valid[1] = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (resp_valid) break;
        end
        repeat (10) begin
            @(negedge clk);
            chk("bp_resp_valid", 32'(resp_valid), 32'd1);
            chk("bp_resp_id", 32'(resp_id), 32'd2);
            chk("bp_resp_value", 32'(resp_value), 32'h09);
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        addr_q.push_back(4'd10);
        addr_q.push_back(4'd11);
        begin
            exp_t e;
            e.id  = 2'd1;
            e.val = 8'h08;
            sb_q.push_back(e);
        end
        @(negedge clk);
        @(negedge clk);
        chk("accept_after_hs", 32'(req_ready), 32'b0010);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        drain();

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        chk("addr_drained", 32'(addr_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
